dds_phase2amp: RTL and testbench

- Phase-to-amplitude stage of the DDS chain; sits directly downstream of the phase accumulator/counter.
- Consumes the accumulator's WIDE_N-bit phase value each valid cycle.
- Truncates the phase to a table address, then produces a signed waveform sample: sine (quarter-wave ROM), square, triangle or sawtooth.
- Fixed 3-stage pipeline with valid tag; output feeds the DAC interface.

---
 rtl/dds_pkg.sv | 32 +++
 rtl/dds_sin_qrom.sv | 38 +++
 rtl/dds_phase2amp.sv | 147 ++++++++++++++
 tb/tb_dds_phase2amp.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// dds_pkg -- shared types and constants for the DDS phase-to-amplitude stage.
//   wave_e         : waveform select encoding (sine, square, triangle, sawtooth)
//   DDS_*          : default phase/address/data widths
//   dds_rom_entry  : quarter-wave sine table entry, evaluated at elaboration
package dds_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  localparam int unsigned DDS_WIDE_N = 12;
  localparam int unsigned DDS_ADDR_W = 8;
  localparam int unsigned DDS_DATA_W = 10;

  // round(MAX * sin(pi/2 * (idx + 0.5) / 2^idx_w)), MAX = 2^(data_w-1)-1.
  // The half-step offset keeps every entry strictly positive and makes the
  // mirrored quadrants reuse the table without duplicating zero or peak.
  function automatic int dds_rom_entry(input int unsigned idx,
                                       input int unsigned idx_w,
                                       input int unsigned data_w);
    real max_v;
    real ang;
    max_v = real'((1 << (data_w - 1)) - 1);
    ang   = 3.14159265358979323846 / 2.0 * (real'(idx) + 0.5)
            / real'(1 << idx_w);
    return $rtoi(max_v * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/dds_sin_qrom.sv
// dds_sin_qrom -- quarter-wave sine ROM with registered synchronous read.
// Ports:
//   clk     : clock
//   rst_n   : asynchronous active-low reset, clears the read register
//   i_en    : read enable (read register loads only when high)
//   i_idx   : table index [IDX_W-1:0]
//   o_data  : registered table entry [DATA_W-1:0], always positive
module dds_sin_qrom
  import dds_pkg::*;
#(
  parameter int unsigned IDX_W  = DDS_ADDR_W - 2,
  parameter int unsigned DATA_W = DDS_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_rom [2**IDX_W];
  logic [DATA_W-1:0] r_data;

  for (genvar g = 0; g < 2**IDX_W; g++) begin : g_rom
    assign w_rom[g] = DATA_W'(dds_rom_entry(g, IDX_W, DATA_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_en) begin
      r_data <= w_rom[i_idx];
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/dds_phase2amp.sv
// dds_phase2amp -- phase-to-amplitude stage of the DDS chain.
// 3-stage pipeline: S1 truncate/capture, S2 quarter-ROM read, S3 sign/select.
// Ports:
//   clk          : clock
//   rst_n        : asynchronous active-low reset, flushes the pipe
//   phase_i      : accumulator phase [WIDE_N-1:0]
//   phase_off_i  : phase offset [WIDE_N-1:0] (only with DDS_PHASE_OFFSET_EN)
//   phase_vld_i  : phase_i valid this cycle
//   wave_sel_i   : 0 sine, 1 square, 2 triangle, 3 sawtooth
//   amp_o        : signed sample [DATA_W-1:0], holds through bubbles
//   amp_vld_o    : amp_o updated this cycle (3 cycles after phase_vld_i)
// Build option: define DDS_PHASE_OFFSET_EN to add phase_off_i, summed
// (mod 2^WIDE_N) with phase_i before truncation.
module dds_phase2amp
  import dds_pkg::*;
#(
  parameter int unsigned WIDE_N = DDS_WIDE_N,
  parameter int unsigned ADDR_W = DDS_ADDR_W,
  parameter int unsigned DATA_W = DDS_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDE_N-1:0]        phase_i,
`ifdef DDS_PHASE_OFFSET_EN
  input  logic [WIDE_N-1:0]        phase_off_i,
`endif
  input  logic                     phase_vld_i,
  input  logic [1:0]               wave_sel_i,
  output logic signed [DATA_W-1:0] amp_o,
  output logic                     amp_vld_o
);

  localparam int unsigned IDX_W  = ADDR_W - 2;
  localparam int unsigned TRI_SH = DATA_W - ADDR_W + 1;
  localparam int unsigned SAW_SH = DATA_W - ADDR_W;
  localparam logic [DATA_W-1:0] AMP_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] AMP_HALF = {1'b1, {(DATA_W-1){1'b0}}};

  // ---------------- S1: phase truncation and capture ----------------
  logic [WIDE_N-1:0] w_phase;
  logic [ADDR_W-1:0] w_addr;

`ifdef DDS_PHASE_OFFSET_EN
  assign w_phase = phase_i + phase_off_i;
`else
  assign w_phase = phase_i;
`endif

  assign w_addr = w_phase[WIDE_N-1 -: ADDR_W];

  // Phase bits below the address are deliberately truncated away.
  if (WIDE_N > ADDR_W) begin : g_lsb
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^w_phase[WIDE_N-ADDR_W-1:0];
  end

  logic              r_s1_vld;
  logic [ADDR_W-1:0] r_s1_addr;
  wave_e             r_s1_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_addr <= '0;
      r_s1_sel  <= WAVE_SINE;
    end else begin
      r_s1_vld <= phase_vld_i;
      if (phase_vld_i) begin
        r_s1_addr <= w_addr;
        r_s1_sel  <= wave_e'(wave_sel_i);
      end
    end
  end

  // ---------------- S2: quarter-ROM read ----------------
  // Odd quadrants walk the table backwards: (2^IDX_W-1) - idx == ~idx.
  logic [IDX_W-1:0]  w_s1_idx;
  logic [IDX_W-1:0]  w_rom_idx;
  logic [DATA_W-1:0] w_rom_data;

  assign w_s1_idx  = r_s1_addr[IDX_W-1:0];
  assign w_rom_idx = r_s1_addr[ADDR_W-2] ? ~w_s1_idx : w_s1_idx;

  dds_sin_qrom #(
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_qrom (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_s1_vld),
    .i_idx  (w_rom_idx),
    .o_data (w_rom_data)
  );

  logic              r_s2_vld;
  logic [ADDR_W-1:0] r_s2_addr;
  wave_e             r_s2_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld  <= 1'b0;
      r_s2_addr <= '0;
      r_s2_sel  <= WAVE_SINE;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_addr <= r_s1_addr;
        r_s2_sel  <= r_s1_sel;
      end
    end
  end

  // ---------------- S3: sign / waveform select ----------------
  logic [DATA_W-1:0] w_amp_nxt;
  logic [ADDR_W-2:0] w_tri_t;

  always_comb begin
    w_amp_nxt = '0;
    w_tri_t   = r_s2_addr[ADDR_W-1] ? ~r_s2_addr[ADDR_W-2:0] : r_s2_addr[ADDR_W-2:0];
    case (r_s2_sel)
      WAVE_SINE:   w_amp_nxt = r_s2_addr[ADDR_W-1] ? -w_rom_data : w_rom_data;
      WAVE_SQUARE: w_amp_nxt = r_s2_addr[ADDR_W-1] ? -AMP_MAX : AMP_MAX;
      WAVE_TRI:    w_amp_nxt = (DATA_W'(w_tri_t) << TRI_SH) - AMP_HALF;
      WAVE_SAW:    w_amp_nxt = (DATA_W'(r_s2_addr) << SAW_SH) - AMP_HALF;
      default:     w_amp_nxt = '0;
    endcase
  end

  logic              r_amp_vld;
  logic [DATA_W-1:0] r_amp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_amp_vld <= 1'b0;
      r_amp     <= '0;
    end else begin
      r_amp_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_amp <= w_amp_nxt;
      end
    end
  end

  assign amp_o     = r_amp;
  assign amp_vld_o = r_amp_vld;

endmodule

// File: tb/tb_dds_phase2amp.sv
// tb_dds_phase2amp -- directed vector bench for dds_phase2amp (default widths).
// Define DDS_PHASE_OFFSET_EN to also exercise the phase offset port.
module tb_dds_phase2amp;

  localparam int unsigned WIDE_N = 12;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 10;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [WIDE_N-1:0]        phase_i;
`ifdef DDS_PHASE_OFFSET_EN
  logic [WIDE_N-1:0]        phase_off_i;
`endif
  logic                     phase_vld_i;
  logic [1:0]               wave_sel_i;
  logic signed [DATA_W-1:0] amp_o;
  logic                     amp_vld_o;

  always #5 clk = ~clk;

  dds_phase2amp #(
    .WIDE_N (WIDE_N),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .phase_i     (phase_i),
`ifdef DDS_PHASE_OFFSET_EN
    .phase_off_i (phase_off_i),
`endif
    .phase_vld_i (phase_vld_i),
    .wave_sel_i  (wave_sel_i),
    .amp_o       (amp_o),
    .amp_vld_o   (amp_vld_o)
  );

  typedef struct {
    string       name;
    int unsigned phase;
    int unsigned off;
    int unsigned sel;
    int          exp;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   last_exp;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: full-cycle sine evaluated directly, no quarter-wave folding.
  function automatic int ref_amp(input int unsigned phase, input int unsigned off,
                                 input int unsigned sel);
    int unsigned addr;
    real         v;
    int          t;
    addr = ((phase + off) % 4096) / 16;
    case (sel)
      0: begin
        v = 511.0 * $sin(2.0 * 3.14159265358979323846 * (real'(addr) + 0.5) / 256.0);
        if (v >= 0.0) return $rtoi(v + 0.5);
        else          return -$rtoi(0.5 - v);
      end
      1: return (addr < 128) ? 511 : -511;
      2: begin
        t = (addr >= 128) ? int'(255 - addr) : int'(addr);
        return t * 8 - 512;
      end
      default: return int'(addr) * 4 - 512;
    endcase
  endfunction

  task automatic run_vec(input vec_t v);
    phase_i     = WIDE_N'(v.phase);
    wave_sel_i  = 2'(v.sel);
`ifdef DDS_PHASE_OFFSET_EN
    phase_off_i = WIDE_N'(v.off);
`endif
    phase_vld_i = 1'b1;
    tick();
    phase_vld_i = 1'b0;
    chk({v.name, "_vld_c1"}, int'(amp_vld_o), 0);
    tick();
    chk({v.name, "_vld_c2"}, int'(amp_vld_o), 0);
    tick();
    chk({v.name, "_vld_c3"}, int'(amp_vld_o), 1);
    chk({v.name, "_amp"}, int'(amp_o), v.exp);
    tick();
    chk({v.name, "_vld_c4"}, int'(amp_vld_o), 0);
    chk({v.name, "_hold"}, int'(amp_o), v.exp);
    last_exp = v.exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned sent;
    int          q[$];
    int          exp_v;
    int unsigned sel_v;

    vecs.push_back('{"sin_000", 'h000, 0, 0, 6});
    vecs.push_back('{"sin_3f0", 'h3F0, 0, 0, 511});
    vecs.push_back('{"sin_400", 'h400, 0, 0, 511});
    vecs.push_back('{"sin_800", 'h800, 0, 0, -6});
    vecs.push_back('{"sin_ff0", 'hFF0, 0, 0, -6});
    vecs.push_back('{"sin_040", 'h040, 0, 0, 56});
    vecs.push_back('{"sin_c00", 'hC00, 0, 0, -511});
    vecs.push_back('{"sq_7ff",  'h7FF, 0, 1, 511});
    vecs.push_back('{"sq_800",  'h800, 0, 1, -511});
    vecs.push_back('{"saw_000", 'h000, 0, 3, -512});
    vecs.push_back('{"saw_fff", 'hFFF, 0, 3, 508});
    vecs.push_back('{"saw_00f", 'h00F, 0, 3, -512});
    vecs.push_back('{"tri_000", 'h000, 0, 2, -512});
    vecs.push_back('{"tri_7f0", 'h7F0, 0, 2, 504});
    vecs.push_back('{"tri_800", 'h800, 0, 2, 504});
    vecs.push_back('{"tri_fff", 'hFFF, 0, 2, -512});
`ifdef DDS_PHASE_OFFSET_EN
    vecs.push_back('{"off_400",  'h000, 'h400, 0, 511});
    vecs.push_back('{"off_wrap", 'h800, 'hC00, 0, 511});
`endif

    // Reset held with valid asserted: outputs stay cleared.
    rst_n       = 1'b0;
    phase_i     = 12'h400;
    phase_vld_i = 1'b1;
    wave_sel_i  = 2'd0;
`ifdef DDS_PHASE_OFFSET_EN
    phase_off_i = '0;
`endif
    #2;
    chk("rst_amp_async", int'(amp_o), 0);
    chk("rst_vld_async", int'(amp_vld_o), 0);
    repeat (4) begin
      tick();
      chk("rst_amp", int'(amp_o), 0);
      chk("rst_vld", int'(amp_vld_o), 0);
    end

    // Release with a valid phase waiting: first pulse exactly 3 cycles later.
    rst_n = 1'b1;
    tick();
    phase_vld_i = 1'b0;
    chk("first_vld_c1", int'(amp_vld_o), 0);
    tick();
    chk("first_vld_c2", int'(amp_vld_o), 0);
    tick();
    chk("first_vld_c3", int'(amp_vld_o), 1);
    chk("first_amp", int'(amp_o), 511);
    tick();
    chk("first_vld_c4", int'(amp_vld_o), 0);
    last_exp = 511;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Streaming: one sample per address, random bubbles, sine -> triangle
    // switch halfway; bubble cycles scramble the inputs, which must not load.
    sent = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (sent == 256 && q.size() == 0) break;
      if (sent < 256 && $urandom_range(0, 3) != 0) begin
        sel_v       = (sent < 128) ? 0 : 2;
        phase_i     = WIDE_N'(sent * 16);
        wave_sel_i  = 2'(sel_v);
        phase_vld_i = 1'b1;
        q.push_back(ref_amp(sent * 16, 0, sel_v));
        sent++;
      end else begin
        phase_i     = WIDE_N'($urandom);
        wave_sel_i  = 2'($urandom);
        phase_vld_i = 1'b0;
      end
      tick();
      if (amp_vld_o) begin
        if (q.size() == 0) begin
          chk("stream_extra_vld", int'(amp_vld_o), 0);
        end else begin
          exp_v = q.pop_front();
          chk("stream_amp", int'(amp_o), exp_v);
          last_exp = exp_v;
        end
      end else begin
        chk("stream_hold", int'(amp_o), last_exp);
      end
    end
    phase_vld_i = 1'b0;
    chk("stream_drained", q.size(), 0);

    // Reset with samples in flight: outputs clear at once, nothing emerges.
    wave_sel_i  = 2'd1;
    phase_vld_i = 1'b1;
    phase_i     = 12'h100;
    tick();
    phase_i     = 12'h200;
    tick();
    phase_i     = 12'h300;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_amp", int'(amp_o), 0);
    chk("midrst_vld", int'(amp_vld_o), 0);
    phase_vld_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      chk("post_rst_vld", int'(amp_vld_o), 0);
      chk("post_rst_amp", int'(amp_o), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
